// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the 2-input gate vector sequencer.
package gate_seq_pkg;
  localparam int VEC_W = 2;

  localparam logic [3:0] TRUTH_AND  = 4'b1000;
  localparam logic [3:0] TRUTH_OR   = 4'b1110;
  localparam logic [3:0] TRUTH_XOR  = 4'b0110;
  localparam logic [3:0] TRUTH_NAND = 4'b0111;
  localparam logic [3:0] TRUTH_NOR  = 4'b0001;

  localparam logic [2:0] ERR_MAX = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/gate_vector_sequencer_hold_timer.sv
// Per-vector hold counter; o_last flags the final cycle of a hold window.
module hold_timer #(
  parameter int HOLD_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_last
);
  localparam logic [7:0] LAST = 8'(HOLD_CYCLES - 1);

  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 8'd1;
  end

  assign o_last = (r_cnt == LAST);
endmodule

// File: rtl/gate_vector_sequencer.sv
// Drives {a,b} through 00..11, samples c at the end of each hold window and
// scores it against TRUTH.
module gate_vector_sequencer
  import gate_seq_pkg::*;
#(
  parameter int         HOLD_CYCLES = 10,
  parameter logic [3:0] TRUTH       = 4'b1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] first_fail,
  output logic       fail_valid
);
  state_e           r_state, w_next;
  logic [VEC_W-1:0] r_vec;
  logic             r_busy, r_done, r_pass, r_fv;
  logic [2:0]       r_err, w_err_nxt;
  logic [1:0]       r_ff;
  logic             w_go, w_cmp, w_mis, w_fin, w_last;

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_go | w_cmp),
    .i_en  (r_state == RUN),
    .o_last(w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_go   = 1'b0;
    w_cmp  = 1'b0;
    case (r_state)
      IDLE, DONE: if (start) begin
        w_next = RUN;
        w_go   = 1'b1;
      end
      RUN: if (w_last) begin
        w_cmp = 1'b1;
        if (r_vec == 2'b11) w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_mis     = w_cmp && (c != TRUTH[r_vec]);
  assign w_fin     = w_cmp && (r_vec == 2'b11);
  assign w_err_nxt = (w_mis && r_err != ERR_MAX) ? r_err + 3'd1 : r_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vec  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_err  <= '0;
      r_ff   <= '0;
      r_fv   <= 1'b0;
    end else if (w_go) begin
      r_vec  <= '0;
      r_busy <= 1'b1;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_err  <= '0;
      r_ff   <= '0;
      r_fv   <= 1'b0;
    end else if (w_cmp) begin
      // 11 -> 00 wrap lands together with the move to DONE
      r_vec <= r_vec + 2'd1;
      r_err <= w_err_nxt;
      if (w_mis && !r_fv) begin
        r_ff <= r_vec;
        r_fv <= 1'b1;
      end
      if (w_fin) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_pass <= (w_err_nxt == 3'd0);
      end
    end
  end

  assign a          = r_vec[1];
  assign b          = r_vec[0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign first_fail = r_ff;
  assign fail_valid = r_fv;
endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Scoreboarded bench: three sequencer instances (H=10 AND, H=1 AND, H=3 XOR).
module tb_gate_vector_sequencer;
  import gate_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic start10 = 0, start1 = 0, start3 = 0;
  logic a10, b10, c10, busy10, done10, pass10, fv10;
  logic a1,  b1,  c1,  busy1,  done1,  pass1,  fv1;
  logic a3,  b3,  c3,  busy3,  done3,  pass3,  fv3;
  logic [2:0] err10, err1, err3;
  logic [1:0] ff10, ff1, ff3;
  logic or_sel = 1'b0;

  assign c10 = or_sel ? (a10 | b10) : (a10 & b10);
  assign c1  = 1'b1;
  assign c3  = a3 ^ b3;

  gate_vector_sequencer #(.HOLD_CYCLES(10), .TRUTH(TRUTH_AND)) u10 (
    .clk(clk), .rst_n(rst_n), .start(start10), .a(a10), .b(b10), .c(c10),
    .busy(busy10), .done(done10), .pass(pass10), .err_count(err10),
    .first_fail(ff10), .fail_valid(fv10));
  gate_vector_sequencer #(.HOLD_CYCLES(1), .TRUTH(TRUTH_AND)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .c(c1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_fail(ff1), .fail_valid(fv1));
  gate_vector_sequencer #(.HOLD_CYCLES(3), .TRUTH(TRUTH_XOR)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .c(c3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_fail(ff3), .fail_valid(fv3));

  typedef struct {
    int         inst;
    int         k;
    int         lat;
    logic [2:0] err;
    logic [1:0] ff;
    logic       fv;
    logic       pass;
  } exp_t;
  exp_t q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic score(int inst, logic [2:0] err, logic [1:0] ff, logic fv, logic ps);
    exp_t e;
    if (q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_done: inst %0d at cycle %0d", inst, cyc);
    end else begin
      e = q.pop_front();
      chk("sb_inst",       inst,      e.inst);
      chk("sb_err_count",  err,       e.err);
      chk("sb_first_fail", ff,        e.ff);
      chk("sb_fail_valid", fv,        e.fv);
      chk("sb_pass",       ps,        e.pass);
      chk("sb_latency",    cyc - e.k, e.lat);
    end
  endtask

  logic pd10 = 0, pd1 = 0, pd3 = 0;
  always @(negedge clk) begin
    if (done10 && !pd10) score(10, err10, ff10, fv10, pass10);
    pd10 <= done10;
  end
  always @(negedge clk) begin
    if (done1 && !pd1) score(1, err1, ff1, fv1, pass1);
    pd1 <= done1;
  end
  always @(negedge clk) begin
    if (done3 && !pd3) score(3, err3, ff3, fv3, pass3);
    pd3 <= done3;
  end

  function automatic logic done_of(int inst);
    case (inst)
      10:      return done10;
      1:       return done1;
      default: return done3;
    endcase
  endfunction

  task automatic set_start(int inst, logic v);
    case (inst)
      10:      start10 = v;
      1:       start1  = v;
      default: start3  = v;
    endcase
  endtask

  // Pulses start for one edge; returns at the negedge after start edge k.
  task automatic go(int inst, output int k);
    @(negedge clk);
    set_start(inst, 1'b1);
    @(posedge clk);
    #1 k = cyc;
    @(negedge clk);
    set_start(inst, 1'b0);
  endtask

  task automatic wait_done(int inst, int maxc);
    int n = 0;
    while (!done_of(inst) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (!done_of(inst)) chk("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic chk_zero10(string tag);
    chk({tag, "_ab"},   {a10, b10}, 0);
    chk({tag, "_busy"}, busy10,     0);
    chk({tag, "_done"}, done10,     0);
    chk({tag, "_pass"}, pass10,     0);
    chk({tag, "_err"},  err10,      0);
    chk({tag, "_ff"},   ff10,       0);
    chk({tag, "_fv"},   fv10,       0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero10("reset");
    chk("reset_busy1", busy1, 0);
    chk("reset_busy3", busy3, 0);
    rst_n = 1'b1;

    // AND gate, H=10: vector stepping and clean pass
    go(10, k);
    q.push_back('{10, k, 40, 3'd0, 2'd0, 1'b0, 1'b1});
    for (int t = 0; t < 40; t++) begin
      if (t % 10 == 0 || t % 10 == 9) chk("ab_step", {a10, b10}, t / 10);
      @(negedge clk);
    end
    wait_done(10, 20);

    // OR gate behind an AND truth table: mismatches on 01 and 10
    or_sel = 1'b1;
    go(10, k);
    q.push_back('{10, k, 40, 3'd2, 2'd1, 1'b1, 1'b0});
    repeat (20) @(negedge clk);
    chk("or_mid_fv",  fv10,  1);
    chk("or_mid_err", err10, 1);
    chk("or_mid_ff",  ff10,  1);
    wait_done(10, 100);
    or_sel = 1'b0;

    // c stuck at 1, H=1
    go(1, k);
    q.push_back('{1, k, 4, 3'd3, 2'd0, 1'b1, 1'b0});
    wait_done(1, 20);

    // reset at edge k+15 aborts the run
    go(10, k);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero10("midrst");
    rst_n = 1'b1;
    go(10, k);
    q.push_back('{10, k, 40, 3'd0, 2'd0, 1'b0, 1'b1});
    wait_done(10, 100);

    // start held high: one run, then immediate restart from DONE
    @(negedge clk);
    start10 = 1'b1;
    @(posedge clk);
    #1 k = cyc;
    q.push_back('{10, k, 40, 3'd0, 2'd0, 1'b0, 1'b1});
    q.push_back('{10, k + 41, 40, 3'd0, 2'd0, 1'b0, 1'b1});
    @(negedge clk);
    repeat (20) @(negedge clk);
    chk("held_busy", busy10,     1);
    chk("held_ab",   {a10, b10}, 2);
    repeat (20) @(negedge clk);
    chk("held_done", done10, 1);
    chk("held_idle", busy10, 0);
    @(negedge clk);
    chk("restart_done", done10,     0);
    chk("restart_busy", busy10,     1);
    chk("restart_ab",   {a10, b10}, 0);
    chk("restart_err",  err10,      0);
    start10 = 1'b0;
    wait_done(10, 100);

    // XOR gate, H=3: busy window exactly edges k..k+11
    chk("xor_pre_busy", busy3, 0);
    go(3, k);
    q.push_back('{3, k, 12, 3'd0, 2'd0, 1'b0, 1'b1});
    for (int t = 0; t <= 12; t++) begin
      chk("xor_busy", busy3, (t < 12) ? 1 : 0);
      @(negedge clk);
    end
    @(negedge clk);

    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
